// File: rtl/hub_link.sv
// hub_link: hub-side endpoint of the serial link to one slave miner. It sends work units out as
// bytes and rebuilds returned nonces. Define HUB_LINK_TIMEOUT_EN to enable the partial-nonce timeout.
module hub_link #(
    parameter int unsigned WORK_BYTES  = 44,
    parameter int unsigned NONCE_BYTES = 4,
    parameter int unsigned RX_TIMEOUT  = 1000000
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     work_valid,
    output logic                     work_ready,
    input  logic [8*WORK_BYTES-1:0]  work_data,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    input  logic                     rx_ready,
    input  logic [7:0]               rx_data,
    output logic                     nonce_valid,
    output logic [8*NONCE_BYTES-1:0] nonce
);

    localparam int unsigned WorkW  = 8 * WORK_BYTES;
    localparam int unsigned NonceW = 8 * NONCE_BYTES;
    localparam int unsigned TxCntW = (WORK_BYTES > 1) ? $clog2(WORK_BYTES) : 1;
    localparam int unsigned RxCntW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StHold, StDrain} tx_state_e;

    tx_state_e           state_q, state_d;
    logic [WorkW-1:0]    active_q, active_d;
    logic [WorkW-1:0]    pending_q, pending_d;
    logic                pend_flag_q, pend_flag_d;
    logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic                tx_last;

    logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [NonceW-1:0]   asm_q, asm_d;
    logic [NonceW-1:0]   nonce_q, nonce_d;
    logic                nonce_valid_q, nonce_valid_d;
    logic                rx_drop;

    assign tx_last = (tx_cnt_q == TxCntW'(WORK_BYTES - 1));

    // Transmit FSM: state register
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Transmit FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pend_flag_q) state_d = StSend;
            StSend:  if (!tx_busy) state_d = StHold;
            StHold:  state_d = tx_last ? StDrain : StSend;
            StDrain: if (!tx_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transmit FSM: outputs
    always_comb begin
        tx_start   = (state_q == StSend) && !tx_busy;
        tx_data    = active_q[WorkW-1 -: 8];
        work_ready = !pend_flag_q;
    end

    // Pending slot can refill while the active unit is still shifting out.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        tx_cnt_d    = tx_cnt_q;
        if (state_q == StIdle && pend_flag_q) begin
            active_d    = pending_q;
            tx_cnt_d    = '0;
            pend_flag_d = 1'b0;
        end
        if (state_q == StHold && !tx_last) begin
            active_d = active_q << 8;
            tx_cnt_d = tx_cnt_q + TxCntW'(1);
        end
        if (work_valid && work_ready) begin
            pending_d   = work_data;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            active_q    <= '0;
            pend_flag_q <= 1'b0;
            tx_cnt_q    <= '0;
        end else begin
            active_q    <= active_d;
            pend_flag_q <= pend_flag_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    always_ff @(posedge hash_clk) begin
        pending_q <= pending_d;
    end

`ifdef HUB_LINK_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;

    always_comb begin
        idle_d  = idle_q;
        rx_drop = 1'b0;
        if (rx_ready || rx_cnt_q == '0) begin
            idle_d = '0;
        end else if (idle_q >= RX_TIMEOUT) begin
            idle_d  = '0;
            rx_drop = 1'b1;
        end else begin
            idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign rx_drop = 1'b0;
`endif

    // Nonce bytes arrive least-significant first.
    always_comb begin
        rx_cnt_d      = rx_cnt_q;
        asm_d         = asm_q;
        nonce_d       = nonce_q;
        nonce_valid_d = 1'b0;
        if (rx_ready) begin
            for (int k = 0; k < NONCE_BYTES; k++) begin
                if (rx_cnt_q == RxCntW'(k)) asm_d[8*k +: 8] = rx_data;
            end
            if (rx_cnt_q == RxCntW'(NONCE_BYTES - 1)) begin
                nonce_d       = asm_d;
                nonce_valid_d = 1'b1;
                rx_cnt_d      = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + RxCntW'(1);
            end
        end else if (rx_drop) begin
            rx_cnt_d = '0;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            rx_cnt_q      <= '0;
            asm_q         <= '0;
            nonce_q       <= '0;
            nonce_valid_q <= 1'b0;
        end else begin
            rx_cnt_q      <= rx_cnt_d;
            asm_q         <= asm_d;
            nonce_q       <= nonce_d;
            nonce_valid_q <= nonce_valid_d;
        end
    end

    assign nonce       = nonce_q;
    assign nonce_valid = nonce_valid_q;

endmodule

// File: tb/tb_hub_link.sv
// tb_hub_link: directed and randomized bench for hub_link with a transaction-level reference model.
// Define HUB_LINK_TIMEOUT_EN to exercise the partial-nonce timeout.
module tb_hub_link;

    localparam int WB = 44;
    localparam int TO = 100;
`ifdef HUB_LINK_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          work_valid = 1'b0;
    logic          work_ready;
    logic [351:0]  work_data = '0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          nonce_valid;
    logic [31:0]   nonce;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0;
    int n_valid = 0;
    int last_start = -100;
    int last_rx = 0;
    int busy_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_bytes[$];
    logic [31:0] exp_nonce[$];
    int          exp_ncyc[$];

    hub_link #(.RX_TIMEOUT(TO)) dut (
        .hash_clk    (clk),
        .reset       (reset),
        .work_valid  (work_valid),
        .work_ready  (work_ready),
        .work_data   (work_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .nonce_valid (nonce_valid),
        .nonce       (nonce)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model and transmitter model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            exp_tx.delete();
            rx_bytes.delete();
            exp_nonce.delete();
            exp_ncyc.delete();
        end else begin
            if (work_valid && work_ready) begin
                for (int i = WB - 1; i >= 0; i--) exp_tx.push_back(work_data[8*i +: 8]);
            end
            if (tx_start) begin
                n_start++;
                chk("tx_while_busy", tx_busy, 0);
                chk("tx_pulse_gap", (cyc - last_start) >= 2, 1);
                last_start = cyc;
                chk("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
            end
            if (nonce_valid) begin
                n_valid++;
                chk("nonce_expected", exp_nonce.size() != 0, 1);
                if (exp_nonce.size() != 0) begin
                    chk("nonce_value", nonce, exp_nonce.pop_front());
                    chk("nonce_latency", cyc, exp_ncyc.pop_front());
                end
            end
            if (rx_ready) begin
                if (TimeoutEn && rx_bytes.size() != 0 && (cyc - last_rx) >= TO + 2) rx_bytes.delete();
                rx_bytes.push_back(rx_data);
                last_rx = cyc;
                if (rx_bytes.size() == 4) begin
                    exp_nonce.push_back({rx_bytes[3], rx_bytes[2], rx_bytes[1], rx_bytes[0]});
                    exp_ncyc.push_back(cyc + 1);
                    rx_bytes.delete();
                end
            end
        end
        if (tx_start && !reset) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [351:0] d, input string tag);
        work_data  = d;
        work_valid = 1'b1;
        @(negedge clk);
        chk(tag, work_ready, 1);
        tick();
        work_valid = 1'b0;
    endtask

    task automatic offer_fresh(input logic [351:0] d);
        offer(d, "accept_idle");
        @(negedge clk);
        chk("latency_cycle1", tx_start, 0);
        tick();
        @(negedge clk);
        chk("latency_cycle2", tx_start, 1);
        tick();
    endtask

    task automatic wait_tx_done(input string tag);
        int n = 0;
        while ((exp_tx.size() != 0 || tx_busy) && n < 5000) begin
            tick();
            n++;
        end
        chk(tag, exp_tx.size(), 0);
        repeat (3) tick();
    endtask

    task automatic wait_starts(input int base, input int cnt);
        int n = 0;
        while ((n_start - base) < cnt && n < 2000) begin
            tick();
            n++;
        end
        chk("reach_byte", (n_start - base) >= cnt, 1);
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic logic [351:0] rand_unit();
        logic [351:0] d;
        for (int i = 0; i < WB; i++) d[8*i +: 8] = 8'($urandom);
        return d;
    endfunction

    initial begin
        logic [351:0] d;
        int base;
        int vbase;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_work_ready", work_ready, 1);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_nonce_valid", nonce_valid, 0);
        chk("rst_nonce", nonce, 0);
        tick();
        reset = 1'b0;
        tick();

        // Unit of bytes 0x01..0x2C, MSB byte first
        for (int i = 0; i < WB; i++) d[8*(WB-1-i) +: 8] = 8'(i + 1);
        base = n_start;
        offer_fresh(d);
        wait_tx_done("unit_a_drain");
        chk("unit_a_starts", n_start - base, 44);

        // Second unit queued during byte 5; third refused
        base = n_start;
        offer_fresh(rand_unit());
        wait_starts(base, 5);
        offer(rand_unit(), "accept_queued");
        work_data  = rand_unit();
        work_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("refuse_third", work_ready, 0);
            tick();
        end
        work_valid = 1'b0;
        wait_tx_done("unit_bc_drain");
        chk("unit_bc_starts", n_start - base, 88);

        // Nonce with gaps, then back-to-back
        vbase = n_valid;
        rx_byte(8'hEF, 2);
        rx_byte(8'hBE, 2);
        rx_byte(8'hAD, 2);
        rx_byte(8'hDE, 3);
        chk("nonce_gapped", nonce, 32'hDEADBEEF);
        rx_byte(8'hEF, 0);
        rx_byte(8'hBE, 0);
        rx_byte(8'hAD, 0);
        rx_byte(8'hDE, 3);
        chk("nonce_b2b", nonce, 32'hDEADBEEF);
        chk("nonce_b2b_count", n_valid - vbase, 2);
        repeat (5) tick();
        chk("nonce_hold", nonce, 32'hDEADBEEF);

        // Random nonces while a random unit is in flight
        vbase = n_valid;
        base  = n_start;
        offer_fresh(rand_unit());
        for (int n = 0; n < 6; n++) begin
            for (int b = 0; b < 4; b++) rx_byte(8'($urandom), $urandom_range(0, 4));
        end
        wait_tx_done("unit_e_drain");
        chk("unit_e_starts", n_start - base, 44);
        chk("rand_nonce_count", n_valid - vbase, 6);
        chk("rand_nonce_drain", exp_nonce.size(), 0);

        // Reset at byte 20 with a unit pending
        base = n_start;
        offer_fresh(rand_unit());
        wait_starts(base, 20);
        offer(rand_unit(), "accept_before_reset");
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", work_ready, 1);
        tick();
        base = n_start;
        repeat (30) tick();
        chk("no_tx_after_reset", n_start - base, 0);
        offer_fresh(rand_unit());
        wait_tx_done("unit_h_drain");
        chk("unit_h_starts", n_start - base, 44);

        // Partial nonce followed by a long gap
        vbase = n_valid;
        rx_byte(8'hAA, 0);
        rx_byte(8'hBB, 150);
        rx_byte(8'h78, 1);
        rx_byte(8'h56, 1);
        rx_byte(8'h34, 1);
        rx_byte(8'h12, 3);
`ifdef HUB_LINK_TIMEOUT_EN
        chk("timeout_nonce", nonce, 32'h12345678);
`else
        chk("no_timeout_nonce", nonce, 32'h5678BBAA);
`endif
        chk("timeout_count", n_valid - vbase, 1);
        chk("final_nonce_drain", exp_nonce.size(), 0);
        chk("final_tx_drain", exp_tx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
